// File: rtl/saradc_pkg.sv
// Shared types for the SAR ADC digital controller: FSM state encoding and
// the width helper used to size the track-phase counter.
package saradc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAMP = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_e;

  // A counter that must reach n-1 needs at least one bit, even for n == 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/saradc_sar_ctrl_if.sv
// Signal bundle between the SAR controller (master) and the analog front end
// plus the code consumer (slave).
interface saradc_sar_ctrl_if #(parameter int NBITS = 8);

  logic             start;
  logic             cmpo;
  logic             sample;
  logic [NBITS-1:0] resultp;
  logic [NBITS-1:0] resultn;
  logic             valid;
  logic             busy;
  logic [NBITS-1:0] dout;
  logic             dvalid;
  logic             dready;

  modport master (
    input  start, cmpo, dready,
    output sample, resultp, resultn, valid, busy, dout, dvalid
  );

  modport slave (
    output start, cmpo, dready,
    input  sample, resultp, resultn, valid, busy, dout, dvalid
  );

endinterface

// File: rtl/saradc_sar_reg.sv
// Successive-approximation register: a one-hot trial mask walking MSB to LSB,
// a thermometer of decided+trial bits, and the P/N result buses.
module saradc_sar_reg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic             cmp,
  output logic [NBITS-1:0] resultp,
  output logic [NBITS-1:0] resultn,
  output logic             last
);

  localparam logic [NBITS-1:0] MSB = {1'b1, {(NBITS-1){1'b0}}};

  logic [NBITS-1:0] trial;
  logic [NBITS-1:0] span;
  logic [NBITS-1:0] sar;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trial <= '0;
      span  <= '0;
      sar   <= '0;
    end else if (clr) begin
      trial <= '0;
      span  <= '0;
      sar   <= '0;
    end else if (load) begin
      trial <= MSB;
      span  <= MSB;
      sar   <= MSB;
    end else if (step) begin
      // Resolve the current trial bit and raise the next one in the same edge.
      sar   <= (sar & ~trial) | ({NBITS{cmp}} & trial) | (trial >> 1);
      trial <= trial >> 1;
      span  <= span | (trial >> 1);
    end
  end

  assign resultp = sar;
  assign resultn = ~sar & span;
  assign last    = trial[0];

endmodule

// File: rtl/saradc_sar_ctrl.sv
// SAR ADC controller: sample -> bit-trial -> done FSM with a valid/ready code
// port. Define SARADC_CONT_EN to allow back-to-back conversions from DONE.
module saradc_sar_ctrl
  import saradc_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int NSAMPLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  saradc_sar_ctrl_if.master bus
);

  localparam int             CW        = cnt_width(NSAMPLE);
  localparam logic [CW-1:0]  SAMP_LAST = CW'(NSAMPLE - 1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          clr;
  logic          load;
  logic          step;
  logic          last;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    clr  = 1'b0;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      IDLE:    clr  = bus.start;
      SAMP:    load = (cnt == SAMP_LAST);
      CONV:    step = 1'b1;
      DONE:    clr  = bus.dready;
      default: ;
    endcase
  end

  saradc_sar_reg #(.NBITS(NBITS)) u_sar_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (load),
    .step    (step),
    .cmp     (bus.cmpo),
    .resultp (bus.resultp),
    .resultn (bus.resultn),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.sample <= 1'b0;
      bus.valid  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.dout   <= '0;
      bus.dvalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SAMP;
            cnt        <= '0;
            bus.sample <= 1'b1;
            bus.busy   <= 1'b1;
          end
        end
        SAMP: begin
          if (cnt == SAMP_LAST) begin
            state      <= CONV;
            bus.sample <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONV: begin
          if (last) begin
            state      <= DONE;
            bus.valid  <= 1'b1;
            bus.dvalid <= 1'b1;
            bus.dout   <= {bus.resultp[NBITS-1:1], bus.cmpo};
          end
        end
        DONE: begin
          if (bus.dready) begin
            bus.valid  <= 1'b0;
            bus.dvalid <= 1'b0;
`ifdef SARADC_CONT_EN
            if (bus.start) begin
              state      <= SAMP;
              cnt        <= '0;
              bus.sample <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
`else
            state    <= IDLE;
            bus.busy <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
